// File: rtl/seq_adder_if.sv
// Valid/ready bus for seq_adder: operand side (in_*) and result side (out_*).
interface seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cy;
  logic             ovf;

  modport master (
    output in_valid, a, b, c, sub, out_ready,
    input  in_ready, out_valid, s, cy, ovf
  );

  modport slave (
    input  in_valid, a, b, c, sub, out_ready,
    output in_ready, out_valid, s, cy, ovf
  );
endinterface

// File: rtl/seq_adder.sv
// Chunked add/subtract unit: WIDTH-bit operands processed CHUNK bits per cycle,
// LSB chunk first, through a registered carry; reports carry-out and signed overflow.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_adder_if.slave  bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               cy_q, cy_d;
  logic               ovf_q, ovf_d;

  logic [CHUNK:0]     sum;
  logic [WIDTH-1:0]   res_next;

  assign sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

  // New chunk enters at the MSB end so the first (LSB) chunk ends up at bit 0.
  if (CHUNK == WIDTH) begin : g_single
    assign res_next = sum[CHUNK-1:0];
  end else begin : g_multi
    assign res_next = {sum[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c;
          sa_d    = bus.a[WIDTH-1];
          sb_d    = bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum[CHUNK];
        res_d   = res_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          s_d     = res_next;
          cy_d    = sum[CHUNK];
          ovf_d   = (sa_q == sb_q) && (res_next[WIDTH-1] != sa_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and
  // clears operand/carry registers too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.cy        = cy_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: default 16/4 build plus 3/1 and 8/8 builds
// checked against a full-precision reference.
module tb_seq_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a_in, b_in;
  logic        c_in, sub_in, in_valid, out_ready;
  int          sel;
  int          n_checks = 0;
  int          n_pass   = 0;

  seq_adder_if #(.WIDTH(16)) if16 ();
  seq_adder_if #(.WIDTH(3))  if3 ();
  seq_adder_if #(.WIDTH(8))  if8 ();

  seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  seq_adder #(.WIDTH(3),  .CHUNK(1)) dut3  (.clk(clk), .rst(rst), .bus(if3));
  seq_adder #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(if8));

  assign if16.in_valid  = in_valid && (sel == 0);
  assign if3.in_valid   = in_valid && (sel == 1);
  assign if8.in_valid   = in_valid && (sel == 2);
  assign if16.out_ready = out_ready && (sel == 0);
  assign if3.out_ready  = out_ready && (sel == 1);
  assign if8.out_ready  = out_ready && (sel == 2);
  assign if16.a = a_in;       assign if16.b = b_in;
  assign if3.a  = a_in[2:0];  assign if3.b  = b_in[2:0];
  assign if8.a  = a_in[7:0];  assign if8.b  = b_in[7:0];
  assign if16.c = c_in;  assign if3.c = c_in;  assign if8.c = c_in;
  assign if16.sub = sub_in; assign if3.sub = sub_in; assign if8.sub = sub_in;

  logic        obs_ir, obs_ov, obs_cy, obs_ovf;
  logic [15:0] obs_s;
  always_comb begin
    obs_ir = if16.in_ready; obs_ov = if16.out_valid;
    obs_s  = if16.s; obs_cy = if16.cy; obs_ovf = if16.ovf;
    if (sel == 1) begin
      obs_ir = if3.in_ready; obs_ov = if3.out_valid;
      obs_s  = {13'd0, if3.s}; obs_cy = if3.cy; obs_ovf = if3.ovf;
    end else if (sel == 2) begin
      obs_ir = if8.in_ready; obs_ov = if8.out_valid;
      obs_s  = {8'd0, if8.s}; obs_cy = if8.cy; obs_ovf = if8.ovf;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic tsub, input string tag);
    int waited = 0;
    while (!obs_ir && waited < 20) begin tick(); waited++; end
    if (!obs_ir) check({tag, " in_ready timeout"}, 0, 1);
    a_in = ta; b_in = tb_v; c_in = tc; sub_in = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic await_done(input int exp_lat, input string tag);
    int lat = 0;
    while (!obs_ov && lat < 20) begin tick(); lat++; end
    check({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, obs_ov, 0);
    check({tag, " in_ready back"}, obs_ir, 1);
  endtask

  task automatic txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                     input logic tsub, input logic [15:0] es, input logic ecy,
                     input logic eovf, input int lat, input string tag);
    start_op(ta, tb_v, tc, tsub, tag);
    await_done(lat, tag);
    check({tag, " s"}, obs_s, es);
    check({tag, " cy"}, obs_cy, ecy);
    check({tag, " ovf"}, obs_ovf, eovf);
    release_out(tag);
  endtask

  // Full-precision reference: s, carry-out (bit w) and signed overflow.
  task automatic model(input int w, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic tsub, output logic [15:0] es,
                       output logic ecy, output logic eovf);
    int unsigned mask, av, bv, full;
    logic sa, sb, ss;
    mask = (32'd1 << w) - 1;
    av   = {16'd0, ta} & mask;
    bv   = (tsub ? {16'd0, ~tb_v} : {16'd0, tb_v}) & mask;
    full = av + bv + (tsub ? 32'd1 : {31'd0, tc});
    es   = 16'(full & mask);
    ecy  = full[w];
    sa   = av[w-1];
    sb   = bv[w-1];
    ss   = full[w-1];
    eovf = (sa == sb) && (ss != sa);
  endtask

  initial begin
    logic [15:0] es;
    logic        ecy, eovf;
    logic [15:0] ra, rb;
    sel = 0; in_valid = 0; out_ready = 0; a_in = 0; b_in = 0; c_in = 0; sub_in = 0;
    rst = 1'b1;
    repeat (2) tick();
    check("rst in_ready", obs_ir, 1);
    check("rst out_valid", obs_ov, 0);
    check("rst s", obs_s, 0);
    check("rst cy/ovf", {obs_cy, obs_ovf}, 0);
    rst = 1'b0;
    tick();

    // Held result while out_ready stays low.
    start_op(16'hFFFF, 16'h0001, 0, 0, "ffff+1");
    await_done(4, "ffff+1");
    repeat (2) tick();
    check("ffff+1 held valid", obs_ov, 1);
    check("ffff+1 s", obs_s, 16'h0000);
    check("ffff+1 cy", obs_cy, 1);
    check("ffff+1 ovf", obs_ovf, 0);
    release_out("ffff+1");

    txn(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 4, "7fff+1");
    txn(16'h7FFF, 16'h0001, 1, 0, 16'h8001, 0, 1, 4, "7fff+1+c");
    txn(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 4, "5-7");

    // Backpressure: inputs wiggle in DONE, result must not move.
    start_op(16'h00FF, 16'h0F01, 0, 0, "bp");
    await_done(4, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      sub_in = ~sub_in;
      tick();
      check("bp s", obs_s, 16'h1000);
      check("bp cy/ovf", {obs_cy, obs_ovf}, 0);
      check("bp in_ready", obs_ir, 0);
      check("bp out_valid", obs_ov, 1);
    end
    in_valid = 0;
    sub_in = 0;
    release_out("bp");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp no queued op", {obs_ir, obs_ov}, 2'b10);
    end

    txn(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 4, "8000-1");

    // Reset while cnt==2 in RUN.
    start_op(16'hAAAA, 16'h5555, 0, 0, "rst_run");
    repeat (2) tick();
    check("rst_run still busy", obs_ir, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run in_ready", obs_ir, 1);
    check("rst_run out_valid", obs_ov, 0);
    check("rst_run s", obs_s, 0);
    check("rst_run cy/ovf", {obs_cy, obs_ovf}, 0);
    repeat (5) tick();
    check("rst_run no result", obs_ov, 0);
    txn(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0, 4, "1234+1111");

    // WIDTH=3, CHUNK=1: exhaustive over a, b and mode {add c=0, add c=1, sub}.
    sel = 1;
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int m = 0; m < 3; m++) begin
          ra = 16'(ia); rb = 16'(ib);
          model(3, ra, rb, m == 1, m == 2, es, ecy, eovf);
          txn(ra, rb, m == 1, m == 2, es, ecy, eovf, 3, "w3");
        end

    // WIDTH=8, CHUNK=8: corners then random.
    sel = 2;
    txn(16'h007F, 16'h0001, 0, 0, 16'h0080, 0, 1, 1, "w8 7f+1");
    txn(16'h0080, 16'h0001, 0, 1, 16'h007F, 1, 1, 1, "w8 80-1");
    txn(16'h00FF, 16'h00FF, 1, 0, 16'h00FF, 1, 0, 1, "w8 ff+ff+1");
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      model(8, ra, rb, i[0], i[1], es, ecy, eovf);
      txn(ra, rb, i[0], i[1], es, ecy, eovf, 1, "w8 rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
